// File: rtl/rk_mem_arbiter_if.sv
// Shared-port bundle between the CPU/video requesters, the arbiter and the SDRAM controller.
interface rk_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_ack;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_we_n;
  logic [15:0] mem_rdata;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    output cpu_rdata, cpu_ack, vid_rdata, vid_ack, mem_addr, mem_wdata,
           mem_rd, mem_we_n, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    input  cpu_rdata, cpu_ack, vid_rdata, vid_ack, mem_addr, mem_wdata,
           mem_rd, mem_we_n, busy
  );
endinterface

// File: rtl/rk_mem_arbiter.sv
// CPU/video arbiter and fixed-length access sequencer for the Radio-86RK SDRAM port.
// Optional CPU starvation guard: define RK_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no access in flight, requests sampled every edge
// ACC   | strobes held for ACCESS_CYCLES cycles
// ACK   | one-cycle acknowledge to the winner
module rk_mem_arbiter #(
  parameter int ACCESS_CYCLES = 6,
  parameter int MAX_VID_RUN   = 4
) (
  input logic            clk48mhz,
  input logic            reset_n,
  rk_mem_arbiter_if.slave bus
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_sel_cpu, r_is_write;
  logic [17:0]     r_mem_addr;
  logic [7:0]      r_mem_wdata, r_cpu_rdata, r_vid_rdata;
  logic            r_mem_rd, r_mem_we_n, r_cpu_ack, r_vid_ack;
  logic            w_grant_cpu, w_grant_vid, w_last, w_guard;
  logic [7:0]      w_unused_rdata_hi;

  assign w_unused_rdata_hi = bus.mem_rdata[15:8];
  assign w_last = (r_cnt == LAST);

`ifdef RK_ARB_STARVE_GUARD_EN
  logic [2:0] r_vid_run;

  assign w_guard = (r_vid_run == 3'(MAX_VID_RUN));

  always_ff @(posedge clk48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_run <= 3'd0;
    end else if (w_grant_vid) begin
      r_vid_run <= bus.cpu_req ? r_vid_run + 3'd1 : 3'd0;
    end else if (w_grant_cpu) begin
      r_vid_run <= 3'd0;
    end
  end
`else
  // Strict video priority; the run limit has no effect in this build.
  assign w_guard = (MAX_VID_RUN < 0);
`endif

  always_ff @(posedge clk48mhz or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_cpu = 1'b0;
    w_grant_vid = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cpu_req && (!bus.vid_req || w_guard)) begin
          w_grant_cpu = 1'b1;
          w_state_nxt = ACC;
        end else if (bus.vid_req) begin
          w_grant_vid = 1'b1;
          w_state_nxt = ACC;
        end
      end
      ACC:     if (w_last) w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_sel_cpu   <= 1'b0;
      r_is_write  <= 1'b0;
      r_mem_addr  <= 18'd0;
      r_mem_wdata <= 8'd0;
      r_mem_rd    <= 1'b0;
      r_mem_we_n  <= 1'b1;
      r_cpu_rdata <= 8'd0;
      r_vid_rdata <= 8'd0;
      r_cpu_ack   <= 1'b0;
      r_vid_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_cpu) begin
            r_cnt       <= '0;
            r_sel_cpu   <= 1'b1;
            r_is_write  <= bus.cpu_we;
            r_mem_addr  <= {3'b000, bus.cpu_addr};
            r_mem_wdata <= bus.cpu_wdata;
            r_mem_rd    <= ~bus.cpu_we;
            r_mem_we_n  <= ~bus.cpu_we;
          end else if (w_grant_vid) begin
            r_cnt       <= '0;
            r_sel_cpu   <= 1'b0;
            r_is_write  <= 1'b0;
            r_mem_addr  <= {3'b000, bus.vid_addr};
            r_mem_rd    <= 1'b1;
            r_mem_we_n  <= 1'b1;
          end
        end
        ACC: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_mem_rd   <= 1'b0;
            r_mem_we_n <= 1'b1;
            if (!r_is_write) begin
              if (r_sel_cpu) r_cpu_rdata <= bus.mem_rdata[7:0];
              else           r_vid_rdata <= bus.mem_rdata[7:0];
            end
            r_cpu_ack <= r_sel_cpu;
            r_vid_ack <= ~r_sel_cpu;
          end
        end
        default: begin
          r_cpu_ack <= 1'b0;
          r_vid_ack <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_we_n  = r_mem_we_n;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.vid_rdata = r_vid_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.vid_ack   = r_vid_ack;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rk_mem_arbiter.sv
// Directed bench for rk_mem_arbiter (ACCESS_CYCLES=6, MAX_VID_RUN=4); follows RK_ARB_STARVE_GUARD_EN.
module tb_rk_mem_arbiter;
  logic clk48mhz = 1'b0;
  logic reset_n  = 1'b0;

  rk_mem_arbiter_if bus();

  rk_mem_arbiter #(.ACCESS_CYCLES(6), .MAX_VID_RUN(4)) u_dut (
    .clk48mhz (clk48mhz),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #10 clk48mhz = ~clk48mhz;

  int n_checks = 0;
  int n_errors = 0;

  int          t_cpu_at, t_vid_at, t_ncpu, t_nvid, t_nrd, t_nwe;
  logic [17:0] t_addr;
  logic [7:0]  t_wdata;
  logic [5:0]  t_order;
  int          t_ngrant;
  logic        drop_cpu, drop_vid, swap_rdata;
  logic [15:0] next_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe ncyc falling edges; index 1 is the first falling edge after this call.
  task track(input int ncyc);
    t_cpu_at = -1; t_vid_at = -1; t_ncpu = 0; t_nvid = 0; t_nrd = 0; t_nwe = 0;
    t_addr = '0; t_wdata = '0; t_order = '0; t_ngrant = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk48mhz);
      if ((bus.mem_rd || !bus.mem_we_n) && (t_nrd + t_nwe == 0)) begin
        t_addr  = bus.mem_addr;
        t_wdata = bus.mem_wdata;
      end
      if (bus.mem_rd)    t_nrd++;
      if (!bus.mem_we_n) t_nwe++;
      if (bus.cpu_ack) begin
        t_ncpu++;
        if (t_cpu_at < 0) t_cpu_at = i;
        if (t_ngrant < 6) t_order[5 - t_ngrant] = 1'b1;
        t_ngrant++;
        if (drop_cpu) bus.cpu_req = 1'b0;
      end
      if (bus.vid_ack) begin
        t_nvid++;
        if (t_vid_at < 0) t_vid_at = i;
        t_ngrant++;
        if (drop_vid) bus.vid_req = 1'b0;
        if (swap_rdata) bus.mem_rdata = next_rdata;
      end
    end
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 0; bus.vid_addr = '0; bus.mem_rdata = '0;
    drop_cpu = 1; drop_vid = 1; swap_rdata = 0; next_rdata = '0;

    repeat (2) @(negedge clk48mhz);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_rd",    bus.mem_rd, 0);
    chk("rst_we_n",  bus.mem_we_n, 1);
    chk("rst_addr",  bus.mem_addr, 0);
    chk("rst_acks",  {bus.cpu_ack, bus.vid_ack}, 0);
    chk("rst_rdata", {bus.cpu_rdata, bus.vid_rdata}, 0);
    reset_n = 1'b1;
    @(negedge clk48mhz);

    // CPU read alone
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h1234; bus.mem_rdata = 16'h00A5;
    track(10);
    chk("rd_addr",    t_addr, 18'h01234);
    chk("rd_strobes", t_nrd, 6);
    chk("rd_ack_at",  t_cpu_at, 7);
    chk("rd_nack",    t_ncpu, 1);
    chk("rd_vid_ack", t_nvid, 0);
    chk("rd_cpu_rd",  bus.cpu_rdata, 8'hA5);
    chk("rd_vid_rd",  bus.vid_rdata, 8'h00);
    chk("rd_idle",    bus.busy, 0);

    // CPU write
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h7FFF; bus.cpu_wdata = 8'h3C;
    bus.mem_rdata = 16'h00FF;
    track(10);
    chk("wr_addr",   t_addr, 18'h07FFF);
    chk("wr_wdata",  t_wdata, 8'h3C);
    chk("wr_we_cyc", t_nwe, 6);
    chk("wr_rd_cyc", t_nrd, 0);
    chk("wr_nack",   t_ncpu, 1);
    chk("wr_cpu_rd", bus.cpu_rdata, 8'hA5);
    bus.cpu_we = 0;

    // Simultaneous requests: video first, CPU 8 cycles later
    bus.cpu_addr = 15'h0100; bus.vid_addr = 15'h2200; bus.mem_rdata = 16'h1177;
    swap_rdata = 1; next_rdata = 16'h22C8;
    bus.cpu_req = 1; bus.vid_req = 1;
    track(18);
    swap_rdata = 0;
    chk("sim_vid_at",  t_vid_at, 7);
    chk("sim_cpu_at",  t_cpu_at, 15);
    chk("sim_strobes", t_nrd, 12);
    chk("sim_vid_rd",  bus.vid_rdata, 8'h77);
    chk("sim_cpu_rd",  bus.cpu_rdata, 8'hC8);

    // Both held continuously
    drop_cpu = 0; drop_vid = 0; bus.mem_rdata = 16'h0011;
    bus.cpu_req = 1; bus.vid_req = 1;
`ifdef RK_ARB_STARVE_GUARD_EN
    track(48);
    chk("guard_order", t_order, 6'b000010);
    chk("guard_count", t_ngrant, 6);
`else
    track(800);
    chk("starve_cpu", t_ncpu, 0);
    chk("starve_vid", t_nvid, 100);
`endif
    bus.cpu_req = 0; bus.vid_req = 0; drop_cpu = 1; drop_vid = 1;
    repeat (3) @(negedge clk48mhz);

    // Reset mid-access at counter == 3
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0042; bus.mem_rdata = 16'h0099;
    track(4);
    chk("mid_rd_before", bus.mem_rd, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rd",    bus.mem_rd, 0);
    chk("mid_we_n",  bus.mem_we_n, 1);
    chk("mid_busy",  bus.busy, 0);
    chk("mid_addr",  bus.mem_addr, 0);
    chk("mid_cpurd", bus.cpu_rdata, 0);
    bus.cpu_req = 0;
    track(2);
    reset_n = 1'b1;
    track(8);
    chk("mid_no_ack", t_ncpu + t_nvid, 0);
    bus.cpu_req = 1;
    track(10);
    chk("post_ack_at", t_cpu_at, 7);
    chk("post_cpu_rd", bus.cpu_rdata, 8'h99);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
